gpu_core_sequencer: RTL and testbench

//  Host-side controller for one GPU shader core (Main). Consumes a valid/ready command

---
 rtl/gpu_sequencer_pkg.sv | 31 +++
 rtl/gpu_core_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_gpu_core_sequencer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_sequencer_pkg.sv
// Shared definitions for the GPU core sequencer.
// Contents:
//   seq_state_e  - sequencer FSM states
//   cmd_type_e   - command header type field values
//   HDR_*        - bit positions of the command header fields
//   COUNT_W      - width of the header payload-count field
package gpu_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_LOAD       = 2'd1,
    ST_CORE_RESET = 2'd2,
    ST_RUN        = 2'd3
  } seq_state_e;

  typedef enum logic [1:0] {
    CMD_LOAD_INST = 2'b00,
    CMD_LOAD_DATA = 2'b01,
    CMD_START     = 2'b10,
    CMD_RESERVED  = 2'b11
  } cmd_type_e;

  localparam int HDR_TYPE_MSB  = 31;
  localparam int HDR_TYPE_LSB  = 30;
  localparam int HDR_COUNT_MSB = 29;
  localparam int HDR_COUNT_LSB = 16;
  localparam int HDR_ADDR_MSB  = 15;
  localparam int HDR_ADDR_LSB  = 0;
  localparam int COUNT_W       = HDR_COUNT_MSB - HDR_COUNT_LSB + 1;

endpackage

// File: rtl/gpu_core_sequencer.sv
// Host-side controller for one GPU shader core.
// Accepts a valid/ready stream of header and payload words, writes instruction
// or data RAM images into the core over its ext_write port, then pulses the
// core reset and runs the core until it halts or the run times out.
// Ports:
//   clock, reset            - single clock, synchronous active-high reset
//   cmd_valid/ready/data    - host command stream (header or payload word)
//   core_reset_n, core_run  - core control
//   core_halted             - core status, only observed while running
//   ext_write_address/data  - core RAM write port (byte address)
//   ext_enable_write_inst   - one-cycle instruction RAM write strobe
//   ext_enable_write_data   - one-cycle data RAM write strobe
//   busy                    - sequencer not idle
//   done, timeout, error    - sticky status of last run / bad header
//   cycle_count             - run cycles of last/current run, saturating
module gpu_core_sequencer
  import gpu_sequencer_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int WORD_WIDTH     = 32,
  parameter int RESET_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [WORD_WIDTH-1:0]    cmd_data,
  output logic                     core_reset_n,
  output logic                     core_run,
  input  logic                     core_halted,
  output logic [ADDRESS_WIDTH-1:0] ext_write_address,
  output logic [WORD_WIDTH-1:0]    ext_write_data,
  output logic                     ext_enable_write_inst,
  output logic                     ext_enable_write_data,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout,
  output logic                     error,
  output logic [31:0]              cycle_count
);

  localparam int          RST_CNT_W   = $clog2(RESET_CYCLES + 1);
  localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  seq_state_e               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [COUNT_W-1:0]       remain_q, remain_d;
  logic                     target_data_q, target_data_d;
  logic [RST_CNT_W-1:0]     rst_cnt_q, rst_cnt_d;
  logic                     core_reset_n_q, core_reset_n_d;
  logic                     core_run_q, core_run_d;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [WORD_WIDTH-1:0]    wr_data_q, wr_data_d;
  logic                     wr_inst_q, wr_inst_d;
  logic                     wr_dat_q, wr_dat_d;
  logic                     done_q, done_d;
  logic                     timeout_q, timeout_d;
  logic                     error_q, error_d;
  logic [31:0]              cyc_q, cyc_d;

  cmd_type_e                hdr_type;
  logic [COUNT_W-1:0]       hdr_count;
  logic [ADDRESS_WIDTH-1:0] hdr_addr;
  logic                     accept;

  assign hdr_type  = cmd_type_e'(cmd_data[HDR_TYPE_MSB:HDR_TYPE_LSB]);
  assign hdr_count = cmd_data[HDR_COUNT_MSB:HDR_COUNT_LSB];
  // Word alignment: the two low address bits of the header are ignored.
  assign hdr_addr  = ADDRESS_WIDTH'(cmd_data[HDR_ADDR_MSB:HDR_ADDR_LSB])
                     & ~ADDRESS_WIDTH'(3);

  // Ready depends only on state; held low while reset is asserted so the
  // host never sees a handshake that reset would discard.
  assign cmd_ready = !reset && (state_q == ST_IDLE || state_q == ST_LOAD);
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    remain_d       = remain_q;
    target_data_d  = target_data_q;
    rst_cnt_d      = rst_cnt_q;
    core_reset_n_d = core_reset_n_q;
    core_run_d     = core_run_q;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    wr_inst_d      = 1'b0;
    wr_dat_d       = 1'b0;
    done_d         = done_q;
    timeout_d      = timeout_q;
    error_d        = error_q;
    cyc_d          = cyc_q;

    case (state_q)
      ST_IDLE: begin
        core_reset_n_d = 1'b1;
        core_run_d     = 1'b0;
        if (accept) begin
          done_d    = 1'b0;
          timeout_d = 1'b0;
          case (hdr_type)
            CMD_LOAD_INST, CMD_LOAD_DATA: begin
              if (hdr_count != '0) begin
                state_d       = ST_LOAD;
                addr_d        = hdr_addr;
                remain_d      = hdr_count;
                target_data_d = (hdr_type == CMD_LOAD_DATA);
              end
            end
            CMD_START: begin
              state_d        = ST_CORE_RESET;
              core_reset_n_d = 1'b0;
              rst_cnt_d      = '0;
              cyc_d          = '0;
            end
            default: error_d = 1'b1;
          endcase
        end
      end

      ST_LOAD: begin
        if (accept) begin
          wr_addr_d = addr_q;
          wr_data_d = cmd_data;
          wr_inst_d = !target_data_q;
          wr_dat_d  = target_data_q;
          addr_d    = addr_q + ADDRESS_WIDTH'(4);
          remain_d  = remain_q - COUNT_W'(1);
          if (remain_q == COUNT_W'(1)) state_d = ST_IDLE;
        end
      end

      ST_CORE_RESET: begin
        rst_cnt_d = rst_cnt_q + RST_CNT_W'(1);
        if (rst_cnt_q == RST_CNT_W'(RESET_CYCLES - 1)) begin
          core_reset_n_d = 1'b1;
          core_run_d     = 1'b1;
          state_d        = ST_RUN;
        end
      end

      ST_RUN: begin
        cyc_d = sat_inc(cyc_q);
        // Halt takes priority over a timeout landing on the same cycle.
        if (core_halted) begin
          done_d     = 1'b1;
          core_run_d = 1'b0;
          state_d    = ST_IDLE;
        end else if (cyc_d == TIMEOUT_LIM) begin
          timeout_d  = 1'b1;
          core_run_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      remain_q       <= '0;
      target_data_q  <= 1'b0;
      rst_cnt_q      <= '0;
      core_reset_n_q <= 1'b0;
      core_run_q     <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      wr_inst_q      <= 1'b0;
      wr_dat_q       <= 1'b0;
      done_q         <= 1'b0;
      timeout_q      <= 1'b0;
      error_q        <= 1'b0;
      cyc_q          <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      remain_q       <= remain_d;
      target_data_q  <= target_data_d;
      rst_cnt_q      <= rst_cnt_d;
      core_reset_n_q <= core_reset_n_d;
      core_run_q     <= core_run_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      wr_inst_q      <= wr_inst_d;
      wr_dat_q       <= wr_dat_d;
      done_q         <= done_d;
      timeout_q      <= timeout_d;
      error_q        <= error_d;
      cyc_q          <= cyc_d;
    end
  end

  assign core_reset_n          = core_reset_n_q;
  assign core_run              = core_run_q;
  assign ext_write_address     = wr_addr_q;
  assign ext_write_data        = wr_data_q;
  assign ext_enable_write_inst = wr_inst_q;
  assign ext_enable_write_data = wr_dat_q;
  assign busy                  = (state_q != ST_IDLE);
  assign done                  = done_q;
  assign timeout               = timeout_q;
  assign error                 = error_q;
  assign cycle_count           = cyc_q;

endmodule

// File: tb/tb_gpu_core_sequencer.sv
// Directed testbench for gpu_core_sequencer with a behavioural core model
// that raises core_halted a programmable number of run cycles after reset.
module tb_gpu_core_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_data = '0;
  logic        core_reset_n;
  logic        core_run;
  logic        core_halted = 1'b0;
  logic [15:0] ext_write_address;
  logic [31:0] ext_write_data;
  logic        ext_enable_write_inst;
  logic        ext_enable_write_data;
  logic        busy, done, timeout, error;
  logic [31:0] cycle_count;

  gpu_core_sequencer #(
    .ADDRESS_WIDTH (16),
    .WORD_WIDTH    (32),
    .RESET_CYCLES  (4),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .cmd_valid            (cmd_valid),
    .cmd_ready            (cmd_ready),
    .cmd_data             (cmd_data),
    .core_reset_n         (core_reset_n),
    .core_run             (core_run),
    .core_halted          (core_halted),
    .ext_write_address    (ext_write_address),
    .ext_write_data       (ext_write_data),
    .ext_enable_write_inst(ext_enable_write_inst),
    .ext_enable_write_data(ext_enable_write_data),
    .busy                 (busy),
    .done                 (done),
    .timeout              (timeout),
    .error                (error),
    .cycle_count          (cycle_count)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;
  always @(posedge clock) cyc_n <= cyc_n + 1;

  // Core model: counts run cycles since its last reset, halts after halt_after.
  int steps = 0;
  int halt_after = 0;
  always @(posedge clock) begin
    if (!core_reset_n) begin
      steps       <= 0;
      core_halted <= 1'b0;
    end else if (core_run && !core_halted) begin
      steps <= steps + 1;
      if (halt_after != 0 && steps + 1 == halt_after) core_halted <= 1'b1;
    end
  end

  // Write-port monitor.
  typedef struct {
    int          cyc;
    logic        inst;
    logic        dat;
    logic [15:0] a;
    logic [31:0] d;
  } wr_t;
  wr_t wq[$];
  int  both_cnt = 0;
  always @(negedge clock) begin
    if (ext_enable_write_inst || ext_enable_write_data)
      wq.push_back('{cyc_n, ext_enable_write_inst, ext_enable_write_data,
                     ext_write_address, ext_write_data});
    if (ext_enable_write_inst && ext_enable_write_data) both_cnt++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one word; every word in this bench must be taken immediately.
  // Returns at the negedge following the accepting posedge, valid still high.
  task automatic send(input string tag, input logic [31:0] w);
    int waits;
    cmd_valid = 1'b1;
    cmd_data  = w;
    waits     = 0;
    #1;
    while (!cmd_ready && waits < 100) begin
      @(negedge clock);
      #1;
      waits++;
    end
    check_eq({tag, "_accept_wait"}, waits, 0);
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic check_reset_vals(input string p);
    check_eq({p, "_cmd_ready"},    cmd_ready, 0);
    check_eq({p, "_core_reset_n"}, core_reset_n, 0);
    check_eq({p, "_core_run"},     core_run, 0);
    check_eq({p, "_we_inst"},      ext_enable_write_inst, 0);
    check_eq({p, "_we_data"},      ext_enable_write_data, 0);
    check_eq({p, "_addr"},         ext_write_address, 0);
    check_eq({p, "_data"},         ext_write_data, 0);
    check_eq({p, "_busy"},         busy, 0);
    check_eq({p, "_done"},         done, 0);
    check_eq({p, "_timeout"},      timeout, 0);
    check_eq({p, "_error"},        error, 0);
    check_eq({p, "_cycle_count"},  cycle_count, 0);
  endtask

  // Run until the sequencer goes idle, measuring core control activity.
  task automatic run_monitor(output int rst_lo, output int run_hi,
                             output int rdy_bad, output int ok);
    rst_lo = 0; run_hi = 0; rdy_bad = 0; ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) begin
        ok = 1;
        break;
      end
      if (!core_reset_n) rst_lo++;
      if (core_run) run_hi++;
      if (cmd_ready) rdy_bad++;
      @(negedge clock);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] exp_a[3];
    logic [31:0] exp_d[3];
    int rst_lo, run_hi, rdy_bad, ok;

    // Reset state
    repeat (2) @(negedge clock);
    check_reset_vals("rst");
    reset = 1'b0;
    @(negedge clock);
    check_eq("post_rst_cmd_ready", cmd_ready, 1);
    check_eq("post_rst_core_reset_n", core_reset_n, 1);

    // Instruction load, back-to-back
    wq.delete();
    exp_a = '{16'h0010, 16'h0014, 16'h0018};
    exp_d = '{32'hA, 32'hB, 32'hC};
    send("ld_hdr", 32'h0003_0010);
    check_eq("ld_busy", busy, 1);
    for (int i = 0; i < 3; i++) send("ld_word", exp_d[i]);
    idle(2);
    check_eq("ld_nwrites", wq.size(), 3);
    if (wq.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check_eq("ld_inst", wq[i].inst, 1);
        check_eq("ld_dat", wq[i].dat, 0);
        check_eq("ld_addr", wq[i].a, exp_a[i]);
        check_eq("ld_data", wq[i].d, exp_d[i]);
        if (i > 0) check_eq("ld_consecutive", wq[i].cyc - wq[i-1].cyc, 1);
      end
    end
    check_eq("ld_idle", busy, 0);

    // Zero-count load stays idle
    send("zero_hdr", 32'h0000_0040);
    idle(1);
    check_eq("zero_busy", busy, 0);

    // Data load with valid gaps and address wrap
    wq.delete();
    send("dl_hdr", 32'h4002_FFFC);
    send("dl_w1", 32'h1);
    idle(2);
    send("dl_w2", 32'h2);
    idle(2);
    check_eq("dl_nwrites", wq.size(), 2);
    if (wq.size() == 2) begin
      check_eq("dl_dat0", wq[0].dat, 1);
      check_eq("dl_inst0", wq[0].inst, 0);
      check_eq("dl_addr0", wq[0].a, 16'hFFFC);
      check_eq("dl_data0", wq[0].d, 1);
      check_eq("dl_dat1", wq[1].dat, 1);
      check_eq("dl_inst1", wq[1].inst, 0);
      check_eq("dl_addr1", wq[1].a, 16'h0000);
      check_eq("dl_data1", wq[1].d, 2);
      check_eq("dl_gap", wq[1].cyc - wq[0].cyc, 3);
    end
    check_eq("dl_idle", busy, 0);

    // Program load and run to halt
    halt_after = 14;
    send("pg_hdr", 32'h0002_0000);
    send("pg_w0", 32'h0050_0093);
    send("pg_w1", 32'h0010_0073);
    idle(1);
    send("run_start", 32'h8000_0000);
    cmd_valid = 1'b0;
    run_monitor(rst_lo, run_hi, rdy_bad, ok);
    check_eq("run_finished", ok, 1);
    check_eq("run_rst_low_cycles", rst_lo, 4);
    check_eq("run_run_cycles", run_hi, 15);
    check_eq("run_ready_while_busy", rdy_bad, 0);
    check_eq("run_done", done, 1);
    check_eq("run_timeout", timeout, 0);
    check_eq("run_cycle_count", cycle_count, 15);
    check_eq("run_core_run_drop", core_run, 0);
    check_eq("run_cmd_ready", cmd_ready, 1);

    // Timeout run
    halt_after = 0;
    send("to_start", 32'h8000_0000);
    cmd_valid = 1'b0;
    check_eq("to_done_cleared", done, 0);
    run_monitor(rst_lo, run_hi, rdy_bad, ok);
    check_eq("to_finished", ok, 1);
    check_eq("to_run_cycles", run_hi, 50);
    check_eq("to_timeout", timeout, 1);
    check_eq("to_done", done, 0);
    check_eq("to_cycle_count", cycle_count, 50);
    check_eq("to_core_run", core_run, 0);

    // Reserved header
    wq.delete();
    send("rsv_hdr", 32'hC000_0000);
    cmd_valid = 1'b0;
    check_eq("rsv_error", error, 1);
    check_eq("rsv_timeout_cleared", timeout, 0);
    check_eq("rsv_busy", busy, 0);
    idle(2);
    check_eq("rsv_nwrites", wq.size(), 0);
    send("rsv_ld_hdr", 32'h0001_0020);
    send("rsv_ld_w", 32'h55);
    idle(2);
    check_eq("rsv_ld_nwrites", wq.size(), 1);
    if (wq.size() == 1) begin
      check_eq("rsv_ld_inst", wq[0].inst, 1);
      check_eq("rsv_ld_addr", wq[0].a, 16'h0020);
      check_eq("rsv_ld_data", wq[0].d, 32'h55);
    end
    check_eq("rsv_error_sticky", error, 1);

    // Reset in the middle of a load
    send("mr_hdr", 32'h0003_0100);
    send("mr_w0", 32'h11);
    cmd_valid = 1'b0;
    check_eq("mr_strobe_before", ext_enable_write_inst, 1);
    reset = 1'b1;
    @(negedge clock);
    check_reset_vals("mr");
    reset = 1'b0;
    @(negedge clock);
    wq.delete();
    send("mr_new_hdr", 32'h0001_0200);
    send("mr_new_w", 32'h77);
    idle(2);
    check_eq("mr_nwrites", wq.size(), 1);
    if (wq.size() == 1) begin
      check_eq("mr_inst", wq[0].inst, 1);
      check_eq("mr_addr", wq[0].a, 16'h0200);
      check_eq("mr_data", wq[0].d, 32'h77);
    end
    check_eq("mr_idle", busy, 0);

    check_eq("both_strobes", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
